// File: rtl/gpio_message_rx_if.sv
// Signal bundle between the peer-facing GPIO pins, the receiver and the
// LCD/message mux.
//
// Handshake: message_valid is a one-cycle strobe with no ready/back-pressure.
// message_in changes only in the cycle message_valid is high and then holds
// until the next strobe or reset. gpio_ack is a level: high from the valid
// cycle until the peer drops gpio_frame.
interface gpio_message_rx_if #(
    parameter int MSG_BITS = 128
);
    logic                gpio_frame;
    logic                gpio_sclk;
    logic                gpio_sdata;
    logic                gpio_ack;
    logic [MSG_BITS-1:0] message_in;
    logic                message_valid;
    logic                busy;
    logic [7:0]          bit_count;
    logic                frame_error;

    modport master (
        output gpio_frame, gpio_sclk, gpio_sdata,
        input  gpio_ack, message_in, message_valid, busy, bit_count, frame_error
    );

    modport slave (
        input  gpio_frame, gpio_sclk, gpio_sdata,
        output gpio_ack, message_in, message_valid, busy, bit_count, frame_error
    );
endinterface

// File: rtl/gpio_message_rx.sv
// gpio_message_rx: receive end of the board-to-board GPIO message link.
// Synchronizes frame/sclk/sdata into the clock domain, shifts one frame in
// MSB first, publishes the message with a one-cycle valid strobe and raises
// gpio_ack until the peer drops its frame line.
//
// Optional feature macro: GPIO_RX_PARITY_CHECK_EN
//   defined   -> frame is MSG_BITS payload bits plus one even-parity bit
//   undefined -> frame is exactly MSG_BITS payload bits
//
// dbg_state_o encoding: 0 IDLE, 1 SHIFT, 2 DONE, 3 ERROR.
module gpio_message_rx #(
    parameter int MSG_BITS       = 128,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic               clock,
    input  logic               reset,
    gpio_message_rx_if.slave   bus,
    output logic [1:0]         dbg_state_o
);

`ifdef GPIO_RX_PARITY_CHECK_EN
    localparam int FRAME_BITS = MSG_BITS + 1;
`else
    localparam int FRAME_BITS = MSG_BITS;
`endif
    localparam int              TO_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      MSG_BITS_C   = 8'(MSG_BITS);
    localparam logic [7:0]      LAST_BIT_C   = 8'(FRAME_BITS - 1);
    localparam logic [7:0]      FRAME_BITS_C = 8'(FRAME_BITS);
    localparam logic [TO_W-1:0] TO_LAST_C    = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] frame_sync_q, sclk_sync_q, sdata_sync_q;
    logic                   frame_hist_q, sclk_hist_q;
    logic                   frame_s, sdata_s;
    logic                   frame_rise, frame_fall, sclk_rise;

    logic [MSG_BITS-1:0]    shift_q, shift_d;
    logic [MSG_BITS-1:0]    message_q, message_d;
    logic [7:0]             bit_count_q, bit_count_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   valid_q, valid_d;
    logic                   error_q, error_d;
    logic                   ack_q, busy_q;

    // Input synchronizers plus one history flop per edge-detected line.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_sync_q <= '0;
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            frame_hist_q <= 1'b0;
            sclk_hist_q  <= 1'b0;
        end else begin
            frame_sync_q <= {frame_sync_q[SYNC_STAGES-2:0], bus.gpio_frame};
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], bus.gpio_sclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], bus.gpio_sdata};
            frame_hist_q <= frame_sync_q[SYNC_STAGES-1];
            sclk_hist_q  <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign frame_s    = frame_sync_q[SYNC_STAGES-1];
    assign sdata_s    = sdata_sync_q[SYNC_STAGES-1];
    assign frame_rise = frame_s & ~frame_hist_q;
    assign frame_fall = ~frame_s & frame_hist_q;
    assign sclk_rise  = sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;

    // Next-state and datapath decisions; a bit arriving with frame_fall is
    // taken first, so a completing bit still wins over the abort.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        message_d   = message_q;
        bit_count_d = bit_count_q;
        to_cnt_d    = to_cnt_q;
        valid_d     = 1'b0;
        error_d     = error_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_rise) begin
                    shift_d     = '0;
                    bit_count_d = '0;
                    to_cnt_d    = '0;
                    error_d     = 1'b0;
                    state_d     = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (sclk_rise) begin
                    to_cnt_d = '0;
                    if (bit_count_q < FRAME_BITS_C) begin
                        bit_count_d = bit_count_q + 8'd1;
                    end
                    // The parity bit (when present) never enters the payload.
                    if (bit_count_q < MSG_BITS_C) begin
                        shift_d = {shift_q[MSG_BITS-2:0], sdata_s};
                    end
                    if (bit_count_q == LAST_BIT_C) begin
`ifdef GPIO_RX_PARITY_CHECK_EN
                        if ((^shift_q) == sdata_s) begin
                            message_d = shift_q;
                            valid_d   = 1'b1;
                            state_d   = ST_DONE;
                        end else begin
                            error_d = 1'b1;
                            state_d = ST_ERROR;
                        end
`else
                        message_d = {shift_q[MSG_BITS-2:0], sdata_s};
                        valid_d   = 1'b1;
                        state_d   = ST_DONE;
`endif
                    end else if (frame_fall) begin
                        error_d = 1'b1;
                        state_d = ST_ERROR;
                    end
                end else if (frame_fall) begin
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end else if (to_cnt_q == TO_LAST_C) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    error_d  = 1'b1;
                    state_d  = ST_ERROR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            ST_DONE: begin
                if (!frame_s) begin
                    state_d = ST_IDLE;
                end
            end

            ST_ERROR: begin
                if (!frame_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            message_q   <= '0;
            bit_count_q <= '0;
            to_cnt_q    <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            message_q   <= message_d;
            bit_count_q <= bit_count_d;
            to_cnt_q    <= to_cnt_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            ack_q       <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_SHIFT);
        end
    end

    assign bus.gpio_ack      = ack_q;
    assign bus.message_in    = message_q;
    assign bus.message_valid = valid_q;
    assign bus.busy          = busy_q;
    assign bus.bit_count     = bit_count_q;
    assign bus.frame_error   = error_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_gpio_message_rx.sv
// Bench for gpio_message_rx: reset checks, a table of directed frames,
// hand-written timeout and mid-frame-reset sequences, and random frames
// scored against a frame-level outcome model.
module tb_gpio_message_rx;
    localparam int MSG_BITS       = 128;
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 1000;
`ifdef GPIO_RX_PARITY_CHECK_EN
    localparam int FB = MSG_BITS + 1;
`else
    localparam int FB = MSG_BITS;
`endif
    // Input edge to valid strobe: sync chain, edge detect, then one clock.
    localparam int LAT = SYNC_STAGES + 1;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    int         cyc = 0;

    gpio_message_rx_if #(.MSG_BITS(MSG_BITS)) bus ();

    gpio_message_rx #(
        .MSG_BITS      (MSG_BITS),
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [MSG_BITS-1:0] exp_q[$];
    logic [MSG_BITS-1:0] last_good;
    int n_vec = 0;
    int n_err = 0;
    int valid_cnt = 0;
    int last_rise_cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every valid strobe must be expected, on time, and carry the queued message.
    always @(negedge clock) begin
        if (!reset && bus.message_valid) begin
            valid_cnt++;
            check("valid_latency", 128'(cyc - last_rise_cyc), 128'(LAT));
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got message %0h expected no strobe", bus.message_in);
            end else begin
                logic [MSG_BITS-1:0] e;
                e = exp_q.pop_front();
                if (bus.message_in !== e) begin
                    n_err++;
                    $display("FAIL message_in: got %0h expected %0h", bus.message_in, e);
                end
            end
        end
    end

    // Global guard so the run always ends.
    initial begin
        repeat (95000) @(posedge clock);
        $display("FAIL watchdog: cycle budget expired");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b, input int hp, input bit fall_with);
        bus.gpio_sclk  = 1'b0;
        bus.gpio_sdata = b;
        tick(hp);
        bus.gpio_sclk = 1'b1;
        last_rise_cyc = cyc;
        if (fall_with) bus.gpio_frame = 1'b0;
        tick(hp);
    endtask

    task automatic send_bits(input logic [MSG_BITS-1:0] payload, input int nbits,
                             input bit sim_fall, input bit par_ok, input int hp);
        logic par_bit;
        logic b;
        par_bit = (^payload) ^ !par_ok;
        for (int i = 0; i < nbits; i++) begin
            if (i < MSG_BITS) b = payload[MSG_BITS-1-i];
            else if (i == MSG_BITS && FB > MSG_BITS) b = par_bit;
            else b = 1'($urandom_range(0, 1));
            send_bit(b, hp, sim_fall && (i == nbits - 1));
        end
        bus.gpio_sclk = 1'b0;
        tick(hp);
    endtask

    // Ends a frame already in flight and checks everything it should leave behind.
    task automatic close_frame(input string tag, input logic [MSG_BITS-1:0] payload,
                               input int v0, input bit exp_valid, input bit exp_err,
                               input int exp_count);
        if (bus.gpio_frame) begin
            check({tag, "_ack_hold"}, 128'(bus.gpio_ack), 128'(exp_valid));
            if (exp_valid) check({tag, "_state_done"}, 128'(dbg_state), 128'(2));
            bus.gpio_frame = 1'b0;
        end
        tick(LAT + 3);
        if (exp_valid) last_good = payload;
        check({tag, "_valid_pulses"}, 128'(valid_cnt - v0), 128'(exp_valid));
        check({tag, "_ack_low"}, 128'(bus.gpio_ack), 128'(0));
        check({tag, "_frame_error"}, 128'(bus.frame_error), 128'(exp_err));
        check({tag, "_bit_count"}, 128'(bus.bit_count), 128'(exp_count));
        check({tag, "_busy"}, 128'(bus.busy), 128'(0));
        check({tag, "_message_hold"}, bus.message_in, last_good);
        check({tag, "_state_idle"}, 128'(dbg_state), 128'(0));
    endtask

    task automatic run_frame(input string tag, input logic [MSG_BITS-1:0] payload,
                             input int nbits, input bit sim_fall, input bit par_ok,
                             input int hp, input bit exp_valid, input bit exp_err,
                             input int exp_count);
        int v0;
        if (exp_valid) exp_q.push_back(payload);
        v0 = valid_cnt;
        bus.gpio_frame = 1'b1;
        tick(hp);
        send_bits(payload, nbits, sim_fall, par_ok, hp);
        close_frame(tag, payload, v0, exp_valid, exp_err, exp_count);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [MSG_BITS-1:0] payload;
        int  nbits;
        bit  sim_fall;
        bit  par_ok;
        int  hp;
        bit  exp_valid;
        bit  exp_err;
        int  exp_count;
    } vec_t;
    vec_t vecs[$];

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        int v0;
        logic [MSG_BITS-1:0] p;

        vecs.push_back('{128'h20202020202020202020_3A_75_73_65_6E_41, FB, 1'b0, 1'b1, 8, 1'b1, 1'b0, FB});
        vecs.push_back('{128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C, 37, 1'b0, 1'b1, 8, 1'b0, 1'b1, 37});
        vecs.push_back('{128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, FB, 1'b1, 1'b1, 4, 1'b1, 1'b0, FB});
        vecs.push_back('{128'h13579BDF_2468ACE0_FEDCBA98_76543210, 50, 1'b1, 1'b1, 4, 1'b0, 1'b1, 50});
        vecs.push_back('{128'h0, 0, 1'b0, 1'b1, 4, 1'b0, 1'b1, 0});
        vecs.push_back('{{MSG_BITS{1'b1}}, FB + 3, 1'b0, 1'b1, 4, 1'b1, 1'b0, FB});
`ifdef GPIO_RX_PARITY_CHECK_EN
        vecs.push_back('{128'h1, FB, 1'b0, 1'b0, 4, 1'b0, 1'b1, FB});
        vecs.push_back('{128'h1, FB, 1'b0, 1'b1, 4, 1'b1, 1'b0, FB});
`else
        vecs.push_back('{128'h1, FB, 1'b0, 1'b1, 4, 1'b1, 1'b0, FB});
        vecs.push_back('{128'h0, FB, 1'b0, 1'b1, 4, 1'b1, 1'b0, FB});
`endif

        // Reset held 3 cycles with the GPIO lines wiggling.
        reset = 1'b1;
        bus.gpio_frame = 1'b0;
        bus.gpio_sclk  = 1'b0;
        bus.gpio_sdata = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.gpio_frame = 1'($urandom_range(0, 1));
            bus.gpio_sclk  = 1'($urandom_range(0, 1));
            bus.gpio_sdata = 1'($urandom_range(0, 1));
        end
        tick(1);
        check("rst_ack", 128'(bus.gpio_ack), 128'(0));
        check("rst_message", bus.message_in, 128'(0));
        check("rst_valid", 128'(bus.message_valid), 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_bit_count", 128'(bus.bit_count), 128'(0));
        check("rst_frame_error", 128'(bus.frame_error), 128'(0));
        check("rst_state", 128'(dbg_state), 128'(0));
        bus.gpio_frame = 1'b0;
        bus.gpio_sclk  = 1'b0;
        bus.gpio_sdata = 1'b0;
        tick(2);
        reset = 1'b0;
        last_good = '0;
        tick(4);

        // Directed frames.
        foreach (vecs[k]) begin
            run_frame($sformatf("vec%0d", k), vecs[k].payload, vecs[k].nbits, vecs[k].sim_fall,
                      vecs[k].par_ok, vecs[k].hp, vecs[k].exp_valid, vecs[k].exp_err,
                      vecs[k].exp_count);
        end

        // Timeout: 10 bits, then sclk stops with the frame still high.
        bus.gpio_frame = 1'b1;
        tick(4);
        send_bits({$urandom(), $urandom(), $urandom(), $urandom()}, 10, 1'b0, 1'b1, 4);
        t0 = last_rise_cyc;
        while (cyc < t0 + LAT + TIMEOUT_CYCLES - 5) tick(1);
        check("to_busy_before", 128'(bus.busy), 128'(1));
        check("to_err_before", 128'(bus.frame_error), 128'(0));
        while (cyc < t0 + LAT + TIMEOUT_CYCLES + 5) tick(1);
        check("to_err_after", 128'(bus.frame_error), 128'(1));
        check("to_busy_after", 128'(bus.busy), 128'(0));
        check("to_state_error", 128'(dbg_state), 128'(3));
        check("to_ack", 128'(bus.gpio_ack), 128'(0));
        check("to_bit_count", 128'(bus.bit_count), 128'(10));
        bus.gpio_frame = 1'b0;
        tick(LAT + 3);
        check("to_err_sticky", 128'(bus.frame_error), 128'(1));
        check("to_message_hold", bus.message_in, last_good);
        // The next frame_rise clears the sticky flag; complete that frame normally.
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_q.push_back(p);
        v0 = valid_cnt;
        bus.gpio_frame = 1'b1;
        tick(8);
        check("rise_clears_err", 128'(bus.frame_error), 128'(0));
        check("rise_busy", 128'(bus.busy), 128'(1));
        check("rise_bit_count", 128'(bus.bit_count), 128'(0));
        send_bits(p, FB, 1'b0, 1'b1, 4);
        close_frame("after_to", p, v0, 1'b1, 1'b0, FB);

        // Reset in the middle of a frame: no strobe, everything cleared.
        v0 = valid_cnt;
        bus.gpio_frame = 1'b1;
        tick(4);
        send_bits({$urandom(), $urandom(), $urandom(), $urandom()}, 20, 1'b0, 1'b1, 4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        last_good = '0;
        tick(1);
        check("mid_rst_busy", 128'(bus.busy), 128'(0));
        check("mid_rst_bit_count", 128'(bus.bit_count), 128'(0));
        check("mid_rst_message", bus.message_in, 128'(0));
        bus.gpio_frame = 1'b0;
        tick(LAT + 3);
        check("mid_rst_no_valid", 128'(valid_cnt - v0), 128'(0));
        check("mid_rst_state", 128'(dbg_state), 128'(0));

        // Random frames scored against the frame-level outcome model.
        for (int k = 0; k < 14; k++) begin
            int  r, nbits, hp, cnt;
            bit  par_ok, sim_fall, ok;
            r        = $urandom_range(0, 9);
            hp       = $urandom_range(3, 5);
            sim_fall = ($urandom_range(0, 3) == 0);
            par_ok   = (r != 9);
            if (r < 6)      nbits = FB + $urandom_range(0, 2);
            else if (r < 9) nbits = $urandom_range(1, FB - 1);
            else            nbits = FB;
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            // A frame is good when it reached full length with correct parity (if any).
            ok  = (nbits >= FB) && ((FB == MSG_BITS) || par_ok);
            cnt = (nbits >= FB) ? FB : nbits;
            run_frame($sformatf("rnd%0d", k), p, nbits, sim_fall, par_ok, hp, ok, !ok, cnt);
        end

        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
